pipelined_delay_reg: RTL and testbench

PIPELINED_DELAY_REG -- requirements
Module: pipelined_delay_reg

---
 rtl/pipelined_delay_reg.sv | 86 ++++++++
 tb/tb_pipelined_delay_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_delay_reg.sv
// Tapped delay line: DEPTH stages of {data, valid}. The output stage is picked combinationally by tap,
// and a registered count tracks how many stages hold valid data.
module pipelined_delay_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int EDGE  = 0,
   localparam int TW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int FW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   input  logic             din_vld,
   input  logic [TW-1:0]    tap,
   output logic [WIDTH-1:0] qout,
   output logic [WIDTH-1:0] qbout,
   output logic             qvld,
   output logic [FW-1:0]    fill
);

   localparam logic [TW-1:0] TMAX = TW'(DEPTH - 1);

   logic [DEPTH-1:0][WIDTH-1:0] sdata, dnxt;
   logic [DEPTH-1:0]            svld, vnxt;
   logic [FW-1:0]               fill_nxt;
   logic [TW-1:0]               tsel;

   // Next state when not in reset: flush wins over shift.
   always_comb begin
      dnxt     = sdata;
      vnxt     = svld;
      fill_nxt = fill;
      if (flush) begin
         vnxt     = '0;
         fill_nxt = '0;
      end else if (en) begin
         dnxt[0] = din;
         vnxt[0] = din_vld;
         for (int i = 1; i < DEPTH; i++) begin
            dnxt[i] = sdata[i-1];
            vnxt[i] = svld[i-1];
         end
         if (din_vld && !svld[DEPTH-1])
            fill_nxt = fill + FW'(1);
         else if (!din_vld && svld[DEPTH-1])
            fill_nxt = fill - FW'(1);
      end
   end

   generate
      if (EDGE != 0) begin : g_rise
         always_ff @(posedge clk) begin
            if (!rst) begin
               sdata <= '0;
               svld  <= '0;
               fill  <= '0;
            end else begin
               sdata <= dnxt;
               svld  <= vnxt;
               fill  <= fill_nxt;
            end
         end
      end else begin : g_fall
         always_ff @(negedge clk) begin
            if (!rst) begin
               sdata <= '0;
               svld  <= '0;
               fill  <= '0;
            end else begin
               sdata <= dnxt;
               svld  <= vnxt;
               fill  <= fill_nxt;
            end
         end
      end
   endgenerate

   // Out-of-range taps clamp to the last stage; with DEPTH=1 this pins the select to 0.
   assign tsel  = (tap > TMAX) ? TMAX : tap;
   assign qout  = sdata[tsel];
   assign qvld  = svld[tsel];
   assign qbout = ~qout;

endmodule

// File: tb/tb_pipelined_delay_reg.sv
// Directed bench: one vector table run on a falling-edge and a rising-edge instance,
// plus short sequences for tap sweeps, DEPTH=1 and tap clamping.
`timescale 1ns/100ps
module tb_pipelined_delay_reg;

   logic       clk = 1'b0;
   logic       rst, en, flush, din_vld;
   logic [7:0] din;
   logic [1:0] tap;
   logic       tap_d1;
   logic [2:0] tap_d5;

   logic [7:0] q0, qb0, q1, qb1, q2, qb2, q5, qb5;
   logic       v0, v1, v2, v5;
   logic [2:0] f0, f1, f5;
   logic [0:0] f2;

   int total = 0;
   int bad   = 0;

   always #10 clk = ~clk;

   pipelined_delay_reg #(.WIDTH(8), .DEPTH(4), .EDGE(0)) u_fall (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
      .tap(tap), .qout(q0), .qbout(qb0), .qvld(v0), .fill(f0));

   pipelined_delay_reg #(.WIDTH(8), .DEPTH(4), .EDGE(1)) u_rise (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
      .tap(tap), .qout(q1), .qbout(qb1), .qvld(v1), .fill(f1));

   pipelined_delay_reg #(.WIDTH(8), .DEPTH(1), .EDGE(0)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
      .tap(tap_d1), .qout(q2), .qbout(qb2), .qvld(v2), .fill(f2));

   pipelined_delay_reg #(.WIDTH(8), .DEPTH(5), .EDGE(0)) u_d5 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
      .tap(tap_d5), .qout(q5), .qbout(qb5), .qvld(v5), .fill(f5));

   typedef struct {
      logic       rst, en, fl;
      logic [7:0] din;
      logic       dv;
      logic [1:0] tap;
      logic [7:0] eq;
      logic       ev;
      logic [2:0] ef;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];

   function automatic vec_t mk(int r, int e, int f, int d, int v, int t, int q, int qv, int fl);
      vec_t x;
      x.rst = 1'(r);  x.en = 1'(e);  x.fl = 1'(f);  x.din = 8'(d);
      x.dv  = 1'(v);  x.tap = 2'(t); x.eq = 8'(q);  x.ev = 1'(qv);
      x.ef  = 3'(fl);
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic act_edge(input int w);
      if (w == 1) @(posedge clk); else @(negedge clk);
      #1;
   endtask

   task automatic opp_edge(input int w);
      if (w == 1) @(negedge clk); else @(posedge clk);
      #1;
   endtask

   task automatic get(input int w, output logic [7:0] q, output logic [7:0] qb,
                      output logic v, output logic [2:0] f);
      if (w == 1) begin q = q1; qb = qb1; v = v1; f = f1; end
      else        begin q = q0; qb = qb0; v = v0; f = f0; end
   endtask

   // Reads every stage through tap with no clock edge in between.
   task automatic sweep(input int w, input logic ev);
      logic [7:0] q, qb, exp;
      logic       v;
      logic [2:0] f;
      for (int k = 0; k < 4; k++) begin
         tap = 2'(k);
         #1;
         get(w, q, qb, v, f);
         exp = 8'(4 - k);
         chk($sformatf("dut%0d sweep tap%0d q", w, k), {24'h0, q}, {24'h0, exp});
         chk($sformatf("dut%0d sweep tap%0d vld", w, k), {31'h0, v}, {31'h0, ev});
      end
   endtask

   initial begin
      logic [7:0] q, qb, exp5 [4];
      logic       v;
      logic [2:0] f, t5 [4];

      tbl[0]  = mk(0,0,0,8'h00,0,0, 8'h00,0,0);
      tbl[1]  = mk(0,0,0,8'h00,0,0, 8'h00,0,0);
      tbl[2]  = mk(1,1,0,8'hA5,1,3, 8'h00,0,1);
      tbl[3]  = mk(1,1,0,8'h00,0,3, 8'h00,0,1);
      tbl[4]  = mk(1,1,0,8'h00,0,3, 8'h00,0,1);
      tbl[5]  = mk(1,1,0,8'h00,0,3, 8'hA5,1,1);
      tbl[6]  = mk(1,1,0,8'h00,0,3, 8'h00,0,0);
      tbl[7]  = mk(1,1,0,8'h01,1,0, 8'h01,1,1);
      tbl[8]  = mk(1,1,0,8'h02,1,0, 8'h02,1,2);
      tbl[9]  = mk(1,1,0,8'h03,1,0, 8'h03,1,3);
      tbl[10] = mk(1,1,0,8'h04,1,0, 8'h04,1,4);
      tbl[11] = mk(1,0,0,8'hFF,1,1, 8'h03,1,4);
      tbl[12] = mk(1,0,0,8'hFF,1,3, 8'h01,1,4);
      tbl[13] = mk(1,1,1,8'h77,1,0, 8'h04,0,0);
      tbl[14] = mk(1,0,0,8'h00,0,3, 8'h01,0,0);
      tbl[15] = mk(1,1,0,8'h11,1,0, 8'h11,1,1);
      tbl[16] = mk(1,1,0,8'h22,1,1, 8'h11,1,2);
      tbl[17] = mk(0,1,1,8'h33,1,1, 8'h00,0,0);
      tbl[18] = mk(0,0,0,8'h00,0,3, 8'h00,0,0);
      tbl[19] = mk(1,1,0,8'h5C,1,0, 8'h5C,1,1);
      tbl[20] = mk(1,1,0,8'hA0,0,1, 8'h5C,1,1);
      tbl[21] = mk(1,0,0,8'h00,0,0, 8'hA0,0,1);

      tap_d1 = 1'b0;
      tap_d5 = 3'd0;

      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; flush = tbl[i].fl;
            din = tbl[i].din; din_vld = tbl[i].dv; tap = tbl[i].tap;
            // Inputs (rst included) changed since the last active edge; state must not move yet.
            opp_edge(w);
            if (i > 0) begin
               get(w, q, qb, v, f);
               chk($sformatf("dut%0d row%0d hold fill", w, i), {29'h0, f}, {29'h0, tbl[i-1].ef});
            end
            act_edge(w);
            get(w, q, qb, v, f);
            chk($sformatf("dut%0d row%0d qout", w, i),  {24'h0, q},  {24'h0, tbl[i].eq});
            chk($sformatf("dut%0d row%0d qbout", w, i), {24'h0, qb}, {24'h0, ~tbl[i].eq});
            chk($sformatf("dut%0d row%0d qvld", w, i),  {31'h0, v},  {31'h0, tbl[i].ev});
            chk($sformatf("dut%0d row%0d fill", w, i),  {29'h0, f},  {29'h0, tbl[i].ef});
            if (i == 10) sweep(w, 1'b1);
            if (i == 13) sweep(w, 1'b0);
         end
      end

      // DEPTH=1: plain enable-gated register, tap has no effect.
      rst = 1'b0; en = 1'b0; flush = 1'b0; din = 8'h00; din_vld = 1'b0; tap = 2'd0;
      act_edge(0);
      chk("d1 reset q", {24'h0, q2}, 32'h00);
      chk("d1 reset qb", {24'h0, qb2}, 32'hFF);
      chk("d1 reset vld", {31'h0, v2}, 32'h0);
      rst = 1'b1; en = 1'b1; din = 8'h3C; din_vld = 1'b1; tap_d1 = 1'b1;
      act_edge(0);
      chk("d1 load q", {24'h0, q2}, 32'h3C);
      chk("d1 load qb", {24'h0, qb2}, 32'hC3);
      chk("d1 load vld", {31'h0, v2}, 32'h1);
      chk("d1 load fill", {31'h0, f2}, 32'h1);
      en = 1'b0; din = 8'h99; tap_d1 = 1'b0;
      act_edge(0);
      chk("d1 hold q", {24'h0, q2}, 32'h3C);
      chk("d1 hold fill", {31'h0, f2}, 32'h1);
      en = 1'b1; din_vld = 1'b0; tap_d1 = 1'b1;
      act_edge(0);
      chk("d1 shift q", {24'h0, q2}, 32'h99);
      chk("d1 shift vld", {31'h0, v2}, 32'h0);
      chk("d1 shift fill", {31'h0, f2}, 32'h0);

      // DEPTH=5: taps past the last stage clamp to it.
      rst = 1'b0;
      act_edge(0);
      rst = 1'b1; en = 1'b1; din_vld = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         din = 8'(k);
         act_edge(0);
      end
      en = 1'b0;
      #1;
      chk("d5 fill", {29'h0, f5}, 32'd5);
      t5[0] = 3'd0; t5[1] = 3'd4; t5[2] = 3'd5; t5[3] = 3'd7;
      exp5[0] = 8'h05; exp5[1] = 8'h01; exp5[2] = 8'h01; exp5[3] = 8'h01;
      for (int k = 0; k < 4; k++) begin
         tap_d5 = t5[k];
         #1;
         chk($sformatf("d5 tap%0d q", t5[k]), {24'h0, q5}, {24'h0, exp5[k]});
         chk($sformatf("d5 tap%0d vld", t5[k]), {31'h0, v5}, 32'h1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
